ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage consumer of the ID-stage FUNCT code for OP_SPECIAL HI/LO ops: MULT, MULTU, DIV, DIVU,
//  MFHI, MFLO, MTHI, MTLO. Owns architectural HI/LO and runs iterative 32-cycle multiply/divide.
//  Raises a stall request to the pipeline control while an operation is in flight.
// PARAMETERS
//  DATA_WIDTH  32  operand / HI / LO width; iteration count = DATA_WIDTH
// PORTS
//  clk        in   1           core clock
//  rst        in   1           synchronous active-high reset
//  flush      in   1           pipeline flush, aborts in-flight op
//  start      in   1           EX holds a valid OP_SPECIAL instruction this cycle
//  funct      in   6           FUNCT code from decode (`FUNCT_BUS)
//  operand_a  in   DATA_WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source)
//  operand_b  in   DATA_WIDTH  rt value (divisor / multiplier)
//  stall_req  out  1           combinational; hold IF/ID/EX while 1
//  hi         out  DATA_WIDTH  HI register (read by MFHI)
//  lo         out  DATA_WIDTH  LO register (read by MFLO)
// BEHAVIOUR
//  - Reset: hi=0, lo=0, state=IDLE, iteration count=0, stall_req=0.
//  - States: IDLE, RUN. Only IDLE samples start. In RUN, start/funct/operands are ignored.
//  - Long op (MULT/MULTU/DIV/DIVU, divisor!=0) with start=1 in IDLE = cycle 0:
//    - stall_req=1 combinationally; magnitudes latched at edge; state->RUN, count=0.
//    - Cycles 1..32: one shift-add / restoring-subtract step per cycle.
//    - stall_req=1 in cycles 1..31 and 0 in cycle 32, the final step.
//    - HI/LO written at the end of cycle 32; state->IDLE; the result is visible in cycle 33.
//    - The instruction therefore occupies EX for 33 cycles.
//  - Signed ops: operate on magnitudes; product/quotient negated if sign(a)^sign(b); remainder
//    takes sign(a). MULT/MULTU: {hi,lo}=64-bit product. DIV/DIVU: lo=quotient, hi=remainder.
//  - 0x80000000 DIV 0xFFFFFFFF: lo=0x80000000, hi=0 (truncated, no trap).
//  - Divide by zero (operand_b==0): no RUN; lo=0xFFFFFFFF, hi=operand_a at end of cycle 0; stall_req=0.
//  - MTHI/MTLO: hi/lo<=operand_a at end of cycle 0, no stall. MFHI/MFLO: no state change.
//    The EX mux reads hi/lo.
//  - Any other funct: ignored.
//  - flush=1 (sync): state->IDLE, count=0 at edge; HI/LO keep pre-op values.
//    flush=1 forces stall_req=0 that cycle. flush with start in IDLE: start ignored.
//  - rst has priority over flush; flush has priority over start.
// CONFIGURATION
//  MULDIV_FAST_MULT_EN defined: MULT/MULTU finish in cycle 0 via single-cycle 64-bit multiply.
//    {hi,lo} are written at end of cycle 0; stall_req=0; RUN is never entered for multiply.
//  Undefined: MULT/MULTU use the 33-cycle iterative path above. Divide is iterative in both builds.
// STRUCTURE
//  - Add to funct.v: FUNCT_MULT 6'b011000, FUNCT_MULTU 6'b011001, FUNCT_DIV 6'b011010,
//    FUNCT_DIVU 6'b011011, FUNCT_MFHI 6'b010000, FUNCT_MTHI 6'b010001, FUNCT_MFLO 6'b010010,
//    FUNCT_MTLO 6'b010011.
//  - New header muldiv.v: MULDIV_STATE_IDLE/RUN encodings, MULDIV_ITER_BUS width.
//  - Sub-module muldiv_iter_core: shift/accumulate datapath, one step per enable.
//    Outputs a 64-bit {rem/hi, quot/lo} register pair. This top holds the FSM, sign fix-up and HI/LO.
// TESTING
//  1. MULT a=0xFFFFFFFE, b=3
//     -> stall_req=1 cycles 0..31, 0 at 32; cycle 33 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2. DIVU a=100, b=7 -> cycle 33 lo=14, hi=2; start pulses during RUN do not disturb the result.
//  3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  4. DIV a=0x1234, b=0 -> stall_req never 1; next cycle lo=0xFFFFFFFF, hi=0x1234.
//  5. Preload hi=0xAA (MTHI), start DIVU, flush at cycle 10
//     -> cycle 11 state IDLE, stall_req=0, hi=0xAA, lo unchanged.
//  6. MTHI 0x12345678 then MTLO 0x9 -> hi=0x12345678, lo=0x9; rst mid-RUN -> hi=lo=0, stall_req=0.
//     With MULDIV_FAST_MULT_EN: repeat test 1 -> stall_req stays 0, result in cycle 1.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit:
// FUNCT codes for the OP_SPECIAL HI/LO ops and the FSM state encoding.
package ex_muldiv_unit_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic {
    MULDIV_STATE_IDLE = 1'b0,
    MULDIV_STATE_RUN  = 1'b1
  } muldiv_state_e;

  function automatic int muldiv_iter_w(input int dw);
    return $clog2(dw);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift-add multiply or restoring divide,
// one step per enable, on a 64-bit {hi/rem, lo/quot} register pair.
module muldiv_iter_core #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic          is_div,
  input  logic [DW-1:0] a_mag,
  input  logic [DW-1:0] b_mag,
  output logic [2*DW-1:0] acc_nxt
);

  logic [2*DW-1:0] acc_q, acc_d;
  logic [DW-1:0]   opb_q, opb_d;
  logic            div_q, div_d;

  logic [DW-1:0] hi_c, lo_c;
  logic [DW:0]   sum_c, rem_sh_c, diff_c;
  logic          ge_c;

  always_comb begin
    hi_c     = acc_q[2*DW-1:DW];
    lo_c     = acc_q[DW-1:0];
    sum_c    = {1'b0, hi_c} + (lo_c[0] ? {1'b0, opb_q} : '0);
    rem_sh_c = {hi_c, lo_c[DW-1]};
    diff_c   = rem_sh_c - {1'b0, opb_q};
    ge_c     = rem_sh_c >= {1'b0, opb_q};
    // multiply shifts right through the pair, divide shifts left
    if (div_q)
      acc_nxt = {ge_c ? diff_c[DW-1:0] : rem_sh_c[DW-1:0],
                 lo_c[DW-2:0], ge_c};
    else
      acc_nxt = {sum_c, lo_c[DW-1:1]};
  end

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    div_d = div_q;
    if (load) begin
      acc_d = {{DW{1'b0}}, is_div ? a_mag : b_mag};
      opb_d = is_div ? b_mag : a_mag;
      div_d = is_div;
    end else if (step) begin
      acc_d = acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: owns HI/LO, runs 32-step multiply/divide.
// Build option MULDIV_FAST_MULT_EN: single-cycle MULT/MULTU.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int DW = DATA_WIDTH;
  localparam int IW = muldiv_iter_w(DATA_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

  muldiv_state_e state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic          neg_res_q, neg_res_d;
  logic          neg_rem_q, neg_rem_d;
  logic          div_q, div_d;

  logic          is_mul, is_div, sgn, a_neg, b_neg;
  logic [DW-1:0] a_mag, b_mag;
  logic          load, step, stall_c;
  logic [2*DW-1:0] acc_nxt, prod_fix;
  logic [DW-1:0]   quo_fix, rem_fix;

  always_comb begin
    is_mul = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    is_div = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    sgn    = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    a_neg  = sgn && operand_a[DW-1];
    b_neg  = sgn && operand_b[DW-1];
    a_mag  = a_neg ? -operand_a : operand_a;
    b_mag  = b_neg ? -operand_b : operand_b;
  end

  always_comb begin
    prod_fix = neg_res_q ? -acc_nxt : acc_nxt;
    quo_fix  = neg_res_q ? -acc_nxt[DW-1:0] : acc_nxt[DW-1:0];
    rem_fix  = neg_rem_q ? -acc_nxt[2*DW-1:DW]
                         : acc_nxt[2*DW-1:DW];
  end

  muldiv_iter_core #(.DW(DW)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .is_div  (is_div),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div_d     = div_q;
    load      = 1'b0;
    step      = 1'b0;
    stall_c   = 1'b0;
    if (flush) begin
      state_d = MULDIV_STATE_IDLE;
      cnt_d   = '0;
    end else if (state_q == MULDIV_STATE_IDLE) begin
      if (start) begin
        if (is_div && operand_b == '0) begin
          lo_d = '1;
          hi_d = operand_a;
        end else if (is_div || is_mul) begin
`ifdef MULDIV_FAST_MULT_EN
          if (is_mul) begin
            {hi_d, lo_d} = (a_neg ^ b_neg)
              ? -({{DW{1'b0}}, a_mag} * {{DW{1'b0}}, b_mag})
              : ({{DW{1'b0}}, a_mag} * {{DW{1'b0}}, b_mag});
          end else begin
            load    = 1'b1;
            stall_c = 1'b1;
            state_d = MULDIV_STATE_RUN;
          end
`else
          load    = 1'b1;
          stall_c = 1'b1;
          state_d = MULDIV_STATE_RUN;
`endif
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div_d     = is_div;
        end else if (funct == FUNCT_MTHI) begin
          hi_d = operand_a;
        end else if (funct == FUNCT_MTLO) begin
          lo_d = operand_a;
        end
      end
    end else begin
      step  = 1'b1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = MULDIV_STATE_IDLE;
        cnt_d   = '0;
        if (div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end else begin
        stall_c = 1'b1;
      end
    end
  end

  assign stall_req = stall_c && !rst;
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MULDIV_STATE_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div_q     <= div_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit against a plain-arithmetic
// HI/LO model; stall_req is checked cycle by cycle by the driver.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        stall_req;
  logic [31:0] hi, lo;

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .funct     (funct),
    .operand_a (a),
    .operand_b (b),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] hi_m = 0;
  logic [31:0] lo_m = 0;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: compare HI/LO in the cycle each result becomes visible
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, {hi, lo}, {e.hi, e.lo});
    end
  end

  // reference: returns 1 when the op occupies EX for 33 cycles
  function automatic bit model(input logic [5:0] f,
                               input logic [31:0] x,
                               input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    model = 1'b0;
    case (f)
      F_MULT, F_MULTU: begin
        if (f == F_MULT) p = 64'(sx * sy);
        else             p = {32'h0, x} * {32'h0, y};
        {hi_m, lo_m} = p;
`ifndef MULDIV_FAST_MULT_EN
        model = 1'b1;
`endif
      end
      F_DIV, F_DIVU: begin
        if (y == 0) begin
          lo_m = 32'hFFFF_FFFF;
          hi_m = x;
        end else begin
          if (f == F_DIV) begin
            lo_m = 32'(sx / sy);
            hi_m = 32'(sx % sy);
          end else begin
            lo_m = x / y;
            hi_m = x % y;
          end
          model = 1'b1;
        end
      end
      F_MTHI: hi_m = x;
      F_MTLO: lo_m = x;
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, input string nm,
                       input bit noise);
    int  c;
    bit  lng;
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    funct = f;
    a     = x;
    b     = y;
    c     = cyc;
    lng   = model(f, x, y);
    e.due = c + (lng ? 33 : 1);
    e.hi  = hi_m;
    e.lo  = lo_m;
    e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    check({nm, " stall c0"}, {63'b0, stall_req}, {63'b0, lng});
    @(posedge clk);
    #1;
    start = 1'b0;
    if (lng) begin
      for (int k = 1; k <= 32; k++) begin
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          funct = 6'($urandom);
          a     = $urandom;
          b     = $urandom;
        end
        @(negedge clk);
        check({nm, " stall run"}, {63'b0, stall_req},
              {63'b0, (k < 32)});
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
  endtask

  logic [5:0] ops [8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU,
                          F_MFHI, F_MTHI, F_MFLO, F_MTLO};

  initial begin
    exp_t e;
    int   c;
    rst = 1'b1; flush = 1'b0; start = 1'b0;
    funct = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    e = '{cyc, 32'h0, 32'h0, "reset"};
    sb.push_back(e);
    @(negedge clk);
    check("reset stall", {63'b0, stall_req}, 64'h0);

    issue(F_MULT, 32'hFFFF_FFFE, 32'd3, "mult neg", 1'b0);
    check("mult neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(F_DIVU, 32'd100, 32'd7, "divu noise", 1'b1);
    check("divu const", {hi, lo}, {32'd2, 32'd14});
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, "div neg", 1'b0);
    check("div neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(F_DIV, 32'h1234, 32'd0, "div zero", 1'b0);
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", 1'b0);
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", 1'b0);
    issue(F_MTHI, 32'h1234_5678, 32'h0, "mthi", 1'b0);
    issue(F_MTLO, 32'h9, 32'h0, "mtlo", 1'b0);
    issue(F_MFHI, 32'hDEAD, 32'h0, "mfhi", 1'b0);
    issue(6'h3F, 32'hBEEF, 32'h1, "bad funct", 1'b0);

    // flush 10 cycles into a divide keeps HI/LO
    issue(F_MTHI, 32'hAA, 32'h0, "mthi aa", 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1; funct = F_DIVU; a = 32'd5000; b = 32'd3;
    c = cyc;
    e = '{c + 11, hi_m, lo_m, "flush keep"};
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush stall", {63'b0, stall_req}, 64'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("post flush stall", {63'b0, stall_req}, 64'h0);

    // flush together with start in IDLE drops the start
    @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1; funct = F_MTHI; a = 32'hDEAD;
    e = '{cyc + 1, hi_m, lo_m, "flush start"};
    sb.push_back(e);
    @(negedge clk);
    check("flush start stall", {63'b0, stall_req}, 64'h0);
    @(posedge clk);
    #1;
    flush = 1'b0; start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
      issue(ops[$urandom_range(0, 7)], x, y, "random",
            1'($urandom_range(0, 1)));
    end

    // reset in the middle of RUN clears HI/LO
    @(posedge clk);
    #1;
    start = 1'b1; funct = F_DIVU; a = 32'h7777; b = 32'h5;
    c = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst  = 1'b1;
    hi_m = '0;
    lo_m = '0;
    e = '{c + 6, 32'h0, 32'h0, "rst mid run"};
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst stall", {63'b0, stall_req}, 64'h0);

    repeat (3) @(posedge clk);
    check("queue drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
